// File: rtl/minc_pkg.sv
// Shared types and constants for the minc data-RAM arbiter.
package minc_pkg;

    localparam int MINC_AW = 8;
    localparam int MINC_DW = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // Owner of the read response produced by this cycle's access (none for writes/idle).
    function automatic owner_t rsp_owner_of(input logic cpu_gnt, input logic host_gnt,
                                            input logic mem_we);
        owner_t own;
        if (cpu_gnt && !mem_we) begin
            own = OWN_CPU;
        end else if (host_gnt && !mem_we) begin
            own = OWN_HOST;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/minc_starve_ctr.sv
// Saturating count of consecutive denied host cycles; flags when the limit is reached.
module minc_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic host_req,
    input  logic host_gnt,
    output logic at_limit
);

    logic [3:0] cnt_r;

    // Count denied host cycles, clear on grant or withdrawn request, hold at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (host_gnt || !host_req) begin
            cnt_r <= 4'd0;
        end else if (cnt_r != 4'(LIMIT)) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == 4'(LIMIT));

endmodule

// File: rtl/minc_ram_arbiter.sv
// Arbiter sharing minc's single-port data RAM between the CPU core and the host port.
// CPU has fixed priority and may lock the RAM across several accesses.
// Optional feature macro MINC_ARB_STARVE_EN: forces a host grant after STARVE_LIMIT
// consecutive denied host cycles while the arbiter is not locked.
module minc_ram_arbiter
    import minc_pkg::*;
#(
    parameter int AW           = MINC_AW,
    parameter int DW           = MINC_DW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_lock,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter width is 4 bits, so only 1..15 is meaningful.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("minc_ram_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t    state_r;
    owner_t        rsp_owner_r;
    logic          arb_open_s;
    logic          starve_force_s;
    logic          cpu_gnt_s;
    logic          host_gnt_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

`ifdef MINC_ARB_STARVE_EN
    minc_starve_ctr #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (CLK),
        .rst      (RESET),
        .host_req (host_req),
        .host_gnt (host_gnt_s),
        .at_limit (starve_force_s)
    );
`else
    assign starve_force_s = 1'b0;
`endif

    // The cycle that drops cpu_lock is arbitrated as an ordinary idle cycle.
    assign arb_open_s = (state_r == ARB_IDLE) || !cpu_lock;

    // Grant decision: CPU priority, starvation override, lock excludes the host.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (RESET) begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else if (arb_open_s) begin
            if (starve_force_s && host_req) begin
                host_gnt_s = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt_s = 1'b1;
            end else if (host_req) begin
                host_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s  = 1'b0;
                host_gnt_s = 1'b0;
            end
        end else begin
            cpu_gnt_s = cpu_req;
        end
    end

    // RAM bus mux from the winner; bus is all-zero without a grant.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        case ({cpu_gnt_s, host_gnt_s})
            2'b10: begin
                mem_we_s    = cpu_we;
                mem_addr_s  = cpu_addr;
                mem_wdata_s = cpu_wdata;
            end
            2'b01: begin
                mem_we_s    = host_we;
                mem_addr_s  = host_addr;
                mem_wdata_s = host_wdata;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = '0;
                mem_wdata_s = '0;
            end
        endcase
    end

    // Arbiter state and read-response owner; reset drops any in-flight response.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ARB_IDLE;
            rsp_owner_r <= OWN_NONE;
        end else begin
            if (cpu_lock && ((state_r == ARB_LOCK) || cpu_gnt_s)) begin
                state_r <= ARB_LOCK;
            end else begin
                state_r <= ARB_IDLE;
            end
            rsp_owner_r <= rsp_owner_of(cpu_gnt_s, host_gnt_s, mem_we_s);
        end
    end

    assign cpu_gnt     = cpu_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign mem_en      = cpu_gnt_s | host_gnt_s;
    assign mem_we      = mem_we_s;
    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign cpu_rvalid  = (rsp_owner_r == OWN_CPU);
    assign host_rvalid = (rsp_owner_r == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule
